hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Sequences the 5-stage RISC-V pipeline around one shared, single-ported memory with a fixed multi-cycle latency.
- Each pipeline step does an instruction fetch, then a data access if EX/MEM holds a load or store, then one global advance.
- At each advance it resolves load-use stalls, taken-branch flushes and ECALL/EBREAK halts, so the forwarding unit only sees legal operand timing.
- Sits beside the forwarding unit; drives the enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus the memory port select.

Parameters:
- MEM_LAT, 2, cycles per memory access; legal range 1..7.
- CNT_W, 3, width of the latency counter; must satisfy 2**CNT_W > MEM_LAT.
- PERF_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IF_ID_RegisterRs1  in  5  rs1 of instruction in ID.
- IF_ID_RegisterRs2  in  5  rs2 of instruction in ID.
- ID_EX_RegisterRd  in  5  rd of instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_MEM_MemRead  in  1  load in MEM stage.
- EX_MEM_MemWrite  in  1  store in MEM stage.
- branch_taken  in  1  taken branch/jump resolved in EX/MEM.
- halt_req  in  1  ECALL/EBREAK in EX/MEM.
- mem_sel  out  1  0 = memory port serves fetch, 1 = data.
- inst_latch  out  1  pulse: fetch word valid, IF captures it.
- data_latch  out  1  pulse: data word valid, MEM captures it.
- advance  out  1  pulse: EX/MEM and MEM/WB load; gates all below.
- pc_write  out  1  PC register load enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  IF/ID cleared to NOP on this advance.
- ID_EX_bubble  out  1  ID/EX loads zero control (NOP).
- halted  out  1  controller in HALT.
- stall_cnt  out  PERF_W  saturating count of load-use stalls.

Behaviour:
- Async reset: state=FETCH, cnt=0, stall_cnt=0; all 1-bit outputs 0 while rst=1.
- All outputs are combinational from state, cnt and inputs; only state, cnt and stall_cnt are registered.
- FETCH: mem_sel=0; cnt increments each cycle.
  - At cnt==MEM_LAT-1: inst_latch=1 and cnt<=0.
  - If EX_MEM_MemRead|EX_MEM_MemWrite, go to DATA with no advance.
  - Otherwise advance=1 this cycle and stay in FETCH.
- DATA: mem_sel=1; cnt increments each cycle.
  - At cnt==MEM_LAT-1: data_latch=1, advance=1, cnt<=0, go to FETCH.
- Step length: MEM_LAT cycles without a data access; 2*MEM_LAT cycles with one.
  - MEM_LAT=1 with no data access gives advance every cycle.
- In the advance cycle only, in priority order:
  1. halt_req=1: advance=1 (instruction retires), pc_write=0, IF_ID_write=0, ID_EX_bubble=1; next state HALT.
  2. branch_taken=1: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1. Overrides load-use.
  3. Load-use: ID_EX_MemRead=1, ID_EX_RegisterRd!=0, and Rd equals IF_ID_RegisterRs1 or IF_ID_RegisterRs2.
     - pc_write=0, IF_ID_write=0, ID_EX_bubble=1.
     - Fetched word is discarded and the same PC is refetched next step.
     - stall_cnt increments, saturating at all-ones.
  4. Otherwise: pc_write=1, IF_ID_write=1, flush=0, bubble=0.
- Outside the advance cycle, pc_write, IF_ID_write, IF_ID_flush and ID_EX_bubble are all 0.
- HALT:
  - All outputs 0 except halted=1; mem_sel=0; cnt held at 0.
  - Left only by reset.
- Inputs are sampled only in the decision cycle; changes mid-access have no effect.
- Reset asserted mid-access aborts it: no latch pulses, FETCH restarts from cnt=0 after deassertion.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding FETCH=2'd0, DATA=2'd1, HALT=2'd2;
  - MEM_LAT default;
  - constant REG_ZERO=5'd0, used by this block and the forwarding unit.
- One natural sub-module: load_use_detect, purely combinational (Rs1, Rs2, Rd, MemRead -> hazard).
- FSM, latency counter and perf counter stay in hazard_controller.

Test Plan:
- Reset mid-DATA (MEM_LAT=2, rst at cnt=1) -> all outputs 0 at once; after release, inst_latch at cycle 2, no data_latch.
- MEM_LAT=1, no loads/stores -> advance=1, inst_latch=1, pc_write=1 every cycle; mem_sel=0 throughout.
- MEM_LAT=2, EX_MEM_MemRead=1 -> inst_latch at cycle 2, mem_sel=1 for cycles 3-4, data_latch+advance at cycle 4.
- ID_EX_MemRead=1, Rd=5, IF_ID Rs2=5 at advance -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1, stall_cnt 0->1.
  - Same stimulus with Rd=0 -> no stall.
- branch_taken=1 together with the load-use condition above -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; stall_cnt unchanged.
- halt_req=1 at advance -> halted=1 next cycle; advance, latch pulses and pc_write stay 0 for 20 cycles; rst returns to FETCH.
- Force stall_cnt to 16'hFFFF, then one more load-use stall -> stays 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions used by the hazard controller and the forwarding unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HALT  = 2'd2
  } ctrl_state_t;

  localparam int MEM_LAT_DEF = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: the load in EX writes a register the instruction in ID reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic       memRead,
  output logic       hazard
);

  // x0 is hard-wired, so a load targeting it never creates a dependency.
  assign hazard = memRead && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/hazard_controller.sv
// Steps the 5-stage pipeline around a shared single-ported memory and resolves
// load-use stalls, taken-branch flushes and ECALL/EBREAK halts at each advance.
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNT_W   = 3,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        IF_ID_RegisterRs1,
  input  logic [4:0]        IF_ID_RegisterRs2,
  input  logic [4:0]        ID_EX_RegisterRd,
  input  logic              ID_EX_MemRead,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic              branch_taken,
  input  logic              halt_req,
  output logic              mem_sel,
  output logic              inst_latch,
  output logic              data_latch,
  output logic              advance,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_bubble,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  ctrl_state_t      state, nextState;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             loadUse;
  logic             lastCycle;
  logic             memOp;
  logic             stallInc;

  load_use_detect u_loadUse (
    .rs1     (IF_ID_RegisterRs1),
    .rs2     (IF_ID_RegisterRs2),
    .rd      (ID_EX_RegisterRd),
    .memRead (ID_EX_MemRead),
    .hazard  (loadUse)
  );

  assign lastCycle = (cnt == CNT_LAST);
  assign memOp     = EX_MEM_MemRead | EX_MEM_MemWrite;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stallInc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave a value held (latch inference).
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    case (state)
      FETCH: begin
        if (lastCycle) begin
          cntNext = '0;
          if (memOp)         nextState = DATA;
          else if (halt_req) nextState = HALT;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (lastCycle) begin
          cntNext   = '0;
          nextState = halt_req ? HALT : FETCH;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      HALT:    cntNext = '0;
      default: begin
        nextState = FETCH;
        cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    mem_sel      = 1'b0;
    inst_latch   = 1'b0;
    data_latch   = 1'b0;
    advance      = 1'b0;
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    halted       = 1'b0;
    stallInc     = 1'b0;
    // Gated by rst so an aborted access cannot emit a latch or advance pulse.
    if (!rst) begin
      case (state)
        FETCH: begin
          inst_latch = lastCycle;
          advance    = lastCycle && !memOp;
        end
        DATA: begin
          mem_sel    = 1'b1;
          data_latch = lastCycle;
          advance    = lastCycle;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase

      if (advance) begin
        if (halt_req) begin
          ID_EX_bubble = 1'b1;
        end else if (branch_taken) begin
          pc_write     = 1'b1;
          IF_ID_write  = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (loadUse) begin
          // Holding PC and IF/ID discards this fetch; the same PC is refetched next step.
          ID_EX_bubble = 1'b1;
          stallInc     = 1'b1;
        end else begin
          pc_write    = 1'b1;
          IF_ID_write = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: MEM_LAT=2 main instance, MEM_LAT=1 instance,
// and a MEM_LAT=1 instance with a 3-bit stall counter for saturation.
module tb_hazard_controller;

  // Observation vector order: {mem_sel, inst_latch, data_latch, advance,
  //   pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, halted}
  localparam logic [8:0] IDLE   = 9'b000000000;
  localparam logic [8:0] ADV    = 9'b010111000;
  localparam logic [8:0] ILAT   = 9'b010000000;
  localparam logic [8:0] DWAIT  = 9'b100000000;
  localparam logic [8:0] DADV   = 9'b101111000;
  localparam logic [8:0] STALL  = 9'b010100010;
  localparam logic [8:0] BRANCH = 9'b010111110;
  localparam logic [8:0] HALTED = 9'b000000001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rdEx = '0;
  logic       idExMemRead = 1'b0, exMemRead = 1'b0, exMemWrite = 1'b0;
  logic       branchTaken = 1'b0, haltReq = 1'b0;

  logic memSel[3], instLatch[3], dataLatch[3], advance[3], pcWrite[3];
  logic ifIdWrite[3], ifIdFlush[3], idExBubble[3], halted[3];
  logic [15:0] stallA, stallB;
  logic [2:0]  stallC;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_LAT(2), .CNT_W(3), .PERF_W(16)) dutA (
    .clk(clk), .rst(rst),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2), .ID_EX_RegisterRd(rdEx),
    .ID_EX_MemRead(idExMemRead), .EX_MEM_MemRead(exMemRead), .EX_MEM_MemWrite(exMemWrite),
    .branch_taken(branchTaken), .halt_req(haltReq),
    .mem_sel(memSel[0]), .inst_latch(instLatch[0]), .data_latch(dataLatch[0]),
    .advance(advance[0]), .pc_write(pcWrite[0]), .IF_ID_write(ifIdWrite[0]),
    .IF_ID_flush(ifIdFlush[0]), .ID_EX_bubble(idExBubble[0]), .halted(halted[0]),
    .stall_cnt(stallA)
  );

  hazard_controller #(.MEM_LAT(1), .CNT_W(3), .PERF_W(16)) dutB (
    .clk(clk), .rst(rst),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2), .ID_EX_RegisterRd(rdEx),
    .ID_EX_MemRead(idExMemRead), .EX_MEM_MemRead(exMemRead), .EX_MEM_MemWrite(exMemWrite),
    .branch_taken(branchTaken), .halt_req(haltReq),
    .mem_sel(memSel[1]), .inst_latch(instLatch[1]), .data_latch(dataLatch[1]),
    .advance(advance[1]), .pc_write(pcWrite[1]), .IF_ID_write(ifIdWrite[1]),
    .IF_ID_flush(ifIdFlush[1]), .ID_EX_bubble(idExBubble[1]), .halted(halted[1]),
    .stall_cnt(stallB)
  );

  hazard_controller #(.MEM_LAT(1), .CNT_W(3), .PERF_W(3)) dutC (
    .clk(clk), .rst(rst),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2), .ID_EX_RegisterRd(rdEx),
    .ID_EX_MemRead(idExMemRead), .EX_MEM_MemRead(exMemRead), .EX_MEM_MemWrite(exMemWrite),
    .branch_taken(branchTaken), .halt_req(haltReq),
    .mem_sel(memSel[2]), .inst_latch(instLatch[2]), .data_latch(dataLatch[2]),
    .advance(advance[2]), .pc_write(pcWrite[2]), .IF_ID_write(ifIdWrite[2]),
    .IF_ID_flush(ifIdFlush[2]), .ID_EX_bubble(idExBubble[2]), .halted(halted[2]),
    .stall_cnt(stallC)
  );

  function automatic logic [8:0] obs(input int k);
    return {memSel[k], instLatch[k], dataLatch[k], advance[k], pcWrite[k],
            ifIdWrite[k], ifIdFlush[k], idExBubble[k], halted[k]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk); #1;
    check("rst_outs_a", 32'(obs(0)), 32'(IDLE));
    check("rst_outs_b", 32'(obs(1)), 32'(IDLE));
    check("rst_stall_a", 32'(stallA), 32'd0);

    // Plain fetch steps.
    @(negedge clk); rst = 1'b0; #1;
    check("c1_idle", 32'(obs(0)), 32'(IDLE));
    check("lat1_adv_0", 32'(obs(1)), 32'(ADV));
    @(negedge clk); #1;
    check("c2_fetch_adv", 32'(obs(0)), 32'(ADV));
    check("lat1_adv_1", 32'(obs(1)), 32'(ADV));

    // Load in EX/MEM: fetch then data access.
    @(negedge clk); exMemRead = 1'b1; #1;
    check("mem_fetch0", 32'(obs(0)), 32'(IDLE));
    @(negedge clk); #1;
    check("mem_fetch1", 32'(obs(0)), 32'(ILAT));
    @(negedge clk); exMemRead = 1'b0; #1;
    check("data0", 32'(obs(0)), 32'(DWAIT));
    @(negedge clk); #1;
    check("data1", 32'(obs(0)), 32'(DADV));

    // Load-use on rs2.
    @(negedge clk); idExMemRead = 1'b1; rdEx = 5'd5; rs1 = 5'd3; rs2 = 5'd5; #1;
    check("lu_wait", 32'(obs(0)), 32'(IDLE));
    @(negedge clk); #1;
    check("lu_adv", 32'(obs(0)), 32'(STALL));
    check("lu_cnt_before", 32'(stallA), 32'd0);
    @(negedge clk); rdEx = 5'd0; #1;
    check("lu_cnt_after", 32'(stallA), 32'd1);
    check("lu_noadv", 32'(obs(0)), 32'(IDLE));
    @(negedge clk); #1;
    check("rd0_adv", 32'(obs(0)), 32'(ADV));

    // Branch overrides load-use.
    @(negedge clk); rdEx = 5'd5; branchTaken = 1'b1; #1;
    check("rd0_cnt", 32'(stallA), 32'd1);
    @(negedge clk); #1;
    check("br_adv", 32'(obs(0)), 32'(BRANCH));
    @(negedge clk); branchTaken = 1'b0; rs1 = 5'd5; rs2 = 5'd7; #1;
    check("br_cnt", 32'(stallA), 32'd1);
    @(negedge clk); #1;
    check("lu_rs1_adv", 32'(obs(0)), 32'(STALL));

    // Halt.
    @(negedge clk); idExMemRead = 1'b0; haltReq = 1'b1; #1;
    check("lu_rs1_cnt", 32'(stallA), 32'd2);
    @(negedge clk); #1;
    check("halt_adv", 32'(obs(0)), 32'(STALL));
    @(negedge clk); haltReq = 1'b0; #1;
    check("halted_a", 32'(obs(0)), 32'(HALTED));
    check("halted_b", 32'(obs(1)), 32'(HALTED));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); exMemRead = i[0]; #1;
      check("halt_hold", 32'(obs(0)), 32'(HALTED));
    end
    exMemRead = 1'b0;

    // Reset out of HALT, then abort a data access with reset.
    @(negedge clk); rst = 1'b1; #1;
    check("rst_from_halt", 32'(obs(0)), 32'(IDLE));
    @(negedge clk); rst = 1'b0; exMemWrite = 1'b1; #1;
    check("r2_c1", 32'(obs(0)), 32'(IDLE));
    @(negedge clk); #1;
    check("r2_c2", 32'(obs(0)), 32'(ILAT));
    @(negedge clk); exMemWrite = 1'b0; #1;
    check("r2_data0", 32'(obs(0)), 32'(DWAIT));
    @(negedge clk); rst = 1'b1; #1;
    check("rst_mid_data", 32'(obs(0)), 32'(IDLE));
    check("rst_mid_stall", 32'(stallA), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("r3_c1", 32'(obs(0)), 32'(IDLE));
    @(negedge clk); #1;
    check("r3_c2", 32'(obs(0)), 32'(ADV));

    // Stall counter saturation on the 3-bit instance.
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; idExMemRead = 1'b1; rdEx = 5'd5; rs1 = 5'd0; rs2 = 5'd5; #1;
    check("sat_start", 32'(stallC), 32'd0);
    check("sat_stall_pulse", 32'(obs(2)), 32'(STALL));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      if (i == 3) check("sat_mid", 32'(stallC), 32'd3);
      if (i == 7) check("sat_full", 32'(stallC), 32'd7);
      if (i == 8) check("sat_hold", 32'(stallC), 32'd7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
